// File: rtl/vend_controller_if.sv
// rtl/vend_controller_if.sv - vending controller signal bundle (coin, keypad, refill, motor, hopper)
interface vend_controller_if #(
    parameter int SEL_W    = 2,
    parameter int STOCK_W  = 4,
    parameter int CREDIT_W = 3
);
    localparam int NUM_SLOTS = 2 ** SEL_W;

    logic                 coin_valid;
    logic [1:0]           coin_val;
    logic                 sel_valid;
    logic [SEL_W-1:0]     sel;
    logic                 cancel;
    logic                 refill_valid;
    logic [SEL_W-1:0]     refill_slot;
    logic [STOCK_W-1:0]   refill_cnt;
    logic                 disp_req;
    logic [SEL_W-1:0]     disp_slot;
    logic                 disp_ack;
    logic                 chg_req;
    logic                 chg_ack;
    logic                 coin_reject;
    logic                 sel_nack;
    logic [CREDIT_W-1:0]  credit;
    logic [NUM_SLOTS-1:0] sold_out;
    logic                 busy;

    modport master (
        input  coin_valid, coin_val, sel_valid, sel, cancel,
               refill_valid, refill_slot, refill_cnt, disp_ack, chg_ack,
        output disp_req, disp_slot, chg_req, coin_reject, sel_nack,
               credit, sold_out, busy
    );

    modport slave (
        output coin_valid, coin_val, sel_valid, sel, cancel,
               refill_valid, refill_slot, refill_cnt, disp_ack, chg_ack,
        input  disp_req, disp_slot, chg_req, coin_reject, sel_nack,
               credit, sold_out, busy
    );
endinterface

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - vending transaction controller: credit, per-slot stock, dispense then change
module vend_controller #(
    parameter int SEL_W      = 2,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 4,
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 6,
    parameter int CREDIT_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    vend_controller_if.master  bus
);
    localparam int NUM_SLOTS = 2 ** SEL_W;
    localparam logic [STOCK_W-1:0] STOCK_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_CHANGE} state_t;

    state_t               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [STOCK_W-1:0]   stock_q [NUM_SLOTS];
    logic [STOCK_W-1:0]   stock_d [NUM_SLOTS];
    logic                 disp_req_q, disp_req_d;
    logic [SEL_W-1:0]     disp_slot_q, disp_slot_d;
    logic                 chg_req_q, chg_req_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 sel_nack_q, sel_nack_d;
    logic                 busy_q;
    logic [NUM_SLOTS-1:0] sold_out;

    logic [CREDIT_W:0]    coin_units;
    logic [CREDIT_W:0]    credit_sum;
    logic                 coin_ok;
    logic                 sale_ok;
    logic [STOCK_W:0]     refill_sum;

    always_comb begin
        coin_units = '0;
        case (bus.coin_val)
            2'b01:   coin_units = (CREDIT_W+1)'(1);
            2'b10:   coin_units = (CREDIT_W+1)'(2);
            default: coin_units = '0;
        endcase
        credit_sum = {1'b0, credit_q} + coin_units;
        coin_ok    = (coin_units != '0) && (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT));
        sale_ok    = (stock_q[bus.sel] != '0) && (credit_q >= CREDIT_W'(PRICE));
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        stock_d       = stock_q;
        disp_req_d    = disp_req_q;
        disp_slot_d   = disp_slot_q;
        chg_req_d     = chg_req_q;
        coin_reject_d = 1'b0;
        sel_nack_d    = 1'b0;
        refill_sum    = '0;

        case (state_q)
            S_IDLE: begin
                sel_nack_d = bus.sel_valid;
                if (bus.coin_valid) begin
                    if (coin_ok) begin
                        credit_d = credit_sum[CREDIT_W-1:0];
                        state_d  = S_COLLECT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                // cancel beats selection beats coin; a nacked selection leaves the coin path open
                if (bus.cancel) begin
                    state_d       = S_CHANGE;
                    chg_req_d     = 1'b1;
                    coin_reject_d = bus.coin_valid;
                end else if (bus.sel_valid && sale_ok) begin
                    credit_d         = credit_q - CREDIT_W'(PRICE);
                    stock_d[bus.sel] = stock_q[bus.sel] - STOCK_W'(1);
                    disp_slot_d      = bus.sel;
                    disp_req_d       = 1'b1;
                    state_d          = S_DISPENSE;
                    coin_reject_d    = bus.coin_valid;
                end else begin
                    sel_nack_d = bus.sel_valid;
                    if (bus.coin_valid) begin
                        if (coin_ok) credit_d = credit_sum[CREDIT_W-1:0];
                        else         coin_reject_d = 1'b1;
                    end
                end
            end
            S_DISPENSE: begin
                coin_reject_d = bus.coin_valid;
                if (bus.disp_ack) begin
                    disp_req_d = 1'b0;
                    if (credit_q != '0) begin
                        state_d   = S_CHANGE;
                        chg_req_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_CHANGE: begin
                coin_reject_d = bus.coin_valid;
                if (bus.chg_ack) begin
                    credit_d = credit_q - CREDIT_W'(1);
                    if (credit_q == CREDIT_W'(1)) begin
                        chg_req_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // refill lands on top of any same-cycle sale decrement, saturating at full scale
        if ((state_q == S_IDLE || state_q == S_COLLECT) && bus.refill_valid) begin
            refill_sum = {1'b0, stock_d[bus.refill_slot]} + {1'b0, bus.refill_cnt};
            stock_d[bus.refill_slot] = refill_sum[STOCK_W] ? STOCK_MAX : refill_sum[STOCK_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            disp_req_q    <= 1'b0;
            disp_slot_q   <= '0;
            chg_req_q     <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_nack_q    <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            disp_req_q    <= disp_req_d;
            disp_slot_q   <= disp_slot_d;
            chg_req_q     <= chg_req_d;
            coin_reject_q <= coin_reject_d;
            sel_nack_q    <= sel_nack_d;
            busy_q        <= (state_d == S_DISPENSE) || (state_d == S_CHANGE);
            stock_q       <= stock_d;
        end
    end

    always_comb begin
        sold_out = '0;
        for (int i = 0; i < NUM_SLOTS; i++) sold_out[i] = (stock_q[i] == '0);
    end

    assign bus.disp_req    = disp_req_q;
    assign bus.disp_slot   = disp_slot_q;
    assign bus.chg_req     = chg_req_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.sel_nack    = sel_nack_q;
    assign bus.credit      = credit_q;
    assign bus.busy        = busy_q;
    assign bus.sold_out    = sold_out;
endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - self-checking bench for vend_controller
module tb_vend_controller;
    localparam int SEL_W = 2, STOCK_W = 4, INIT_STOCK = 4, PRICE = 3, MAX_CREDIT = 6, CREDIT_W = 3;
    localparam int NUM_SLOTS = 4, STOCK_MAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vend_controller_if #(.SEL_W(SEL_W), .STOCK_W(STOCK_W), .CREDIT_W(CREDIT_W)) bus ();

    vend_controller #(
        .SEL_W(SEL_W), .STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK),
        .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .CREDIT_W(CREDIT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // reference: credit and stock as plain integers, sale phase as two flags
    int m_credit;
    int m_stock [NUM_SLOTS];
    bit m_disp, m_chg, m_rej, m_nack;
    int m_slot;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_update();
        int units;
        bit took;
        m_rej  = 0;
        m_nack = 0;
        if (rst) begin
            m_credit = 0; m_disp = 0; m_chg = 0; m_slot = 0;
            for (int i = 0; i < NUM_SLOTS; i++) m_stock[i] = INIT_STOCK;
            return;
        end
        units = (bus.coin_val == 2'b01) ? 1 : (bus.coin_val == 2'b10) ? 2 : 0;
        if (m_disp) begin
            m_rej = bus.coin_valid;
            if (bus.disp_ack) begin
                m_disp = 0;
                m_chg  = (m_credit > 0);
            end
        end else if (m_chg) begin
            m_rej = bus.coin_valid;
            if (bus.chg_ack) begin
                m_credit--;
                if (m_credit == 0) m_chg = 0;
            end
        end else begin
            took = 0;
            if (m_credit > 0 && bus.cancel) begin
                m_chg = 1;
                took  = 1;
            end else if (bus.sel_valid) begin
                if (m_stock[bus.sel] > 0 && m_credit >= PRICE) begin
                    m_credit -= PRICE;
                    m_stock[bus.sel]--;
                    m_slot = bus.sel;
                    m_disp = 1;
                    took   = 1;
                end else begin
                    m_nack = 1;
                end
            end
            if (bus.coin_valid) begin
                if (took || units == 0 || m_credit + units > MAX_CREDIT) m_rej = 1;
                else m_credit += units;
            end
            if (bus.refill_valid) begin
                m_stock[bus.refill_slot] += bus.refill_cnt;
                if (m_stock[bus.refill_slot] > STOCK_MAX) m_stock[bus.refill_slot] = STOCK_MAX;
            end
        end
    endtask

    task automatic compare_model();
        logic [NUM_SLOTS-1:0] exp_so;
        for (int i = 0; i < NUM_SLOTS; i++) exp_so[i] = (m_stock[i] == 0);
        check("credit",      bus.credit,      m_credit);
        check("disp_req",    bus.disp_req,    m_disp);
        check("disp_slot",   bus.disp_slot,   m_slot);
        check("chg_req",     bus.chg_req,     m_chg);
        check("coin_reject", bus.coin_reject, m_rej);
        check("sel_nack",    bus.sel_nack,    m_nack);
        check("busy",        bus.busy,        m_disp || m_chg);
        check("sold_out",    bus.sold_out,    exp_so);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare_model();
        rst = 0;
        bus.coin_valid = 0; bus.sel_valid = 0; bus.cancel = 0;
        bus.refill_valid = 0; bus.disp_ack = 0; bus.chg_ack = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
    endtask
    task automatic do_coin(input logic [1:0] v);
        bus.coin_valid = 1; bus.coin_val = v; step();
    endtask
    task automatic do_sel(input logic [1:0] s);
        bus.sel_valid = 1; bus.sel = s; step();
    endtask
    task automatic do_cancel();
        bus.cancel = 1; step();
    endtask
    task automatic do_dack();
        bus.disp_ack = 1; step();
    endtask
    task automatic do_cack();
        bus.chg_ack = 1; step();
    endtask
    task automatic do_refill(input logic [1:0] s, input logic [3:0] c);
        bus.refill_valid = 1; bus.refill_slot = s; bus.refill_cnt = c; step();
    endtask

    typedef struct {
        logic       cv;
        logic [1:0] val;
        logic       sv;
        logic [1:0] s;
        logic       cn;
        logic       da;
        logic       ca;
        int         cr;
        logic       dr;
        logic       chr;
        logic       rej;
        logic       nk;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic cv, logic [1:0] val, logic sv, logic [1:0] s, logic cn,
                                logic da, logic ca, int cr, logic dr, logic chr, logic rej, logic nk);
        vec_t v;
        v.cv = cv; v.val = val; v.sv = sv; v.s = s; v.cn = cn; v.da = da; v.ca = ca;
        v.cr = cr; v.dr = dr; v.chr = chr; v.rej = rej; v.nk = nk;
        vecs.push_back(v);
    endfunction

    initial begin
        //  cv val sv s cn da ca | credit disp chg rej nack
        add(1, 2, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0);
        add(0, 0, 1, 2, 0, 0, 0,   0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0);
        add(1, 2, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0);
        add(1, 2, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0,   1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0,   1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        add(1, 2, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0);
        add(1, 2, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0);
        add(1, 2, 0, 0, 0, 0, 0,   6, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0,   6, 0, 0, 1, 0);
        add(1, 3, 0, 0, 0, 0, 0,   6, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0,   6, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0,   3, 1, 0, 0, 0);
        add(1, 2, 0, 0, 0, 0, 0,   3, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0,   3, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0,   3, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1,   2, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1,   1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);

        bus.coin_valid = 0; bus.coin_val = 0; bus.sel_valid = 0; bus.sel = 0; bus.cancel = 0;
        bus.refill_valid = 0; bus.refill_slot = 0; bus.refill_cnt = 0;
        bus.disp_ack = 0; bus.chg_ack = 0;

        do_reset();
        check("rst_credit",   bus.credit,   0);
        check("rst_disp_req", bus.disp_req, 0);
        check("rst_chg_req",  bus.chg_req,  0);
        check("rst_busy",     bus.busy,     0);
        check("rst_sold_out", bus.sold_out, 0);

        foreach (vecs[i]) begin
            bus.coin_valid = vecs[i].cv; bus.coin_val = vecs[i].val;
            bus.sel_valid  = vecs[i].sv; bus.sel      = vecs[i].s;
            bus.cancel     = vecs[i].cn;
            bus.disp_ack   = vecs[i].da; bus.chg_ack  = vecs[i].ca;
            step();
            check($sformatf("vec%0d_credit", i), bus.credit,      vecs[i].cr);
            check($sformatf("vec%0d_disp",   i), bus.disp_req,    vecs[i].dr);
            check($sformatf("vec%0d_chg",    i), bus.chg_req,     vecs[i].chr);
            check($sformatf("vec%0d_rej",    i), bus.coin_reject, vecs[i].rej);
            check($sformatf("vec%0d_nack",   i), bus.sel_nack,    vecs[i].nk);
        end
        check("slot2_after_table", bus.sold_out[2], 0);

        // drain slot 3, refuse the fifth sale, then refill it
        do_reset();
        repeat (4) begin
            do_coin(2'b10); do_coin(2'b01); do_sel(2'd3);
            check("empty_disp_slot", bus.disp_slot, 3);
            do_dack();
        end
        check("slot3_sold_out", bus.sold_out[3], 1);
        do_coin(2'b10); do_coin(2'b01); do_sel(2'd3);
        check("slot3_nack", bus.sel_nack, 1);
        check("slot3_no_disp", bus.disp_req, 0);
        do_cancel();
        repeat (3) do_cack();
        do_refill(2'd3, 4'd15);
        check("slot3_refilled", bus.sold_out[3], 0);

        // 4 + 15 must saturate at 15, not wrap
        do_refill(2'd0, 4'd15);
        for (int n = 0; n < 15; n++) begin
            check("slot0_stock_left", bus.sold_out[0], 0);
            do_coin(2'b10); do_coin(2'b01); do_sel(2'd0); do_dack();
        end
        check("slot0_sat_empty", bus.sold_out[0], 1);

        // nacked selection lets a simultaneous coin through
        do_reset();
        do_coin(2'b01);
        bus.sel_valid = 1; bus.sel = 2; bus.coin_valid = 1; bus.coin_val = 2'b10;
        step();
        check("nack_coin_nack",   bus.sel_nack, 1);
        check("nack_coin_credit", bus.credit,   3);

        // cancel + sel + coin at credit 4, then reset mid-change
        do_reset();
        do_coin(2'b10); do_coin(2'b10);
        bus.cancel = 1; bus.sel_valid = 1; bus.sel = 0; bus.coin_valid = 1; bus.coin_val = 2'b01;
        step();
        check("prio_chg_req", bus.chg_req,     1);
        check("prio_reject",  bus.coin_reject, 1);
        check("prio_no_disp", bus.disp_req,    0);
        check("prio_credit",  bus.credit,      4);
        do_cack();
        check("prio_refund1", bus.credit, 3);
        do_reset();
        check("abort_chg_req", bus.chg_req, 0);
        check("abort_credit",  bus.credit,  0);

        for (int n = 0; n < 3000; n++) begin
            rst              = ($urandom_range(0, 299) == 0);
            bus.coin_valid   = ($urandom_range(0, 3) == 0);
            bus.coin_val     = 2'($urandom_range(0, 3));
            bus.sel_valid    = ($urandom_range(0, 4) == 0);
            bus.sel          = 2'($urandom_range(0, 3));
            bus.cancel       = ($urandom_range(0, 11) == 0);
            bus.refill_valid = ($urandom_range(0, 39) == 0);
            bus.refill_slot  = 2'($urandom_range(0, 3));
            bus.refill_cnt   = 4'($urandom_range(0, 15));
            bus.disp_ack     = ($urandom_range(0, 2) == 0);
            bus.chg_ack      = ($urandom_range(0, 1) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
